rom_reader: RTL and testbench
=============================

# rom_reader

Read initiator for the synchronous single-port `rom` macro. A single `start` command gives a base address and a word count. The block issues `en`/`addr` reads to the ROM, absorbs the ROM's one-cycle read latency, and streams the returned words on a valid/ready output with a last-beat marker. It sits between a ROM instance and any streaming consumer, for example a coefficient loader or a boot sequencer.

## Interface
- DW, 32, data width; must match the attached ROM.
- AW, 6, address width; the ROM holds 2**AW words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base  in  AW  first word address; sampled with `start`.
- len  in  AW+1  number of words, 0..2**AW; sampled with `start`.
- busy  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses.
- done  out  1  one-cycle pulse when the command completes.
- rom_en  out  1  ROM read enable.
- rom_addr  out  AW  ROM address.
- rom_dout  in  DW  ROM read data; valid the cycle after `rom_en`.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DW  output word.
- out_last  out  1  marks the final word of the command; qualified by `out_valid`.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 with `len`>0 → RUN; load address counter = `base`, remaining = `len`.
  - `start`=1 with `len`=0 → no reads; `done` pulses the next cycle; state stays IDLE.
- RUN:
  - A read issues when remaining>0 and (buffer occupancy + in-flight − pop_this_cycle) ≤ 1.
  - Issuing a read means: `rom_en`=1, `rom_addr`=counter, counter+1 modulo 2**AW (so 2**AW−1 wraps to 0), remaining−1, in-flight set for one cycle.
  - When remaining reaches 0 → DRAIN.
- DRAIN:
  - When the buffer is empty, nothing is in flight, and the last word has handshaken → IDLE with a `done` pulse.
- Output buffer:
  - 2-entry FIFO.
  - Written with `rom_dout` in the cycle after each issued read.
  - Popped on `out_valid && out_ready`.
  - Cannot overflow, by the issue rule.
  - `out_last` is set on the word that came from the final read.
- `start` while busy is ignored and has no side effect.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- Reset at any time:
  - State goes to IDLE; buffer, in-flight flag, counters and all outputs are cleared.
  - Pending data is discarded and no `done` pulse is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- Command latency:
  - `start` sampled at edge k → `rom_en`=1 in cycle k+1.
  - That word is on `rom_dout` in cycle k+2 and written to the buffer at edge k+2.
  - `out_valid`=1 from cycle k+3.
- Throughput: with `out_ready` held high, one word per cycle; `len`=N completes its last handshake in cycle k+N+2.
- `done` pulses in the cycle after the last handshake; `busy` drops in that same cycle.
- A new `start` may be presented in the `done` cycle.
- Backpressure:
  - With `out_ready`=0, at most 2 words are buffered and no further reads issue.
  - The first read after `out_ready` rises issues in the same cycle as the pop.
- `rom_en` and `rom_addr` are combinational from registered state and the current `out_ready`/pop; no combinational path runs from `rom_dout`.

## Structure
- Shared package: state encoding constants (IDLE, RUN, DRAIN); `localparam DEPTH = 2**AW`.
- Sub-module `rom_reader_buf`: 2-entry registered FIFO with occupancy output. The top level holds the FSM, counters and issue logic.
- The bench instantiates `rom` with DW/AW matching, initialized with mem[i]=i.

## Test plan
- base=2, len=4, `out_ready`=1 → data 2,3,4,5 on consecutive cycles starting 3 cycles after `start`; `out_last` on 5; `done` the next cycle.
- base=62, len=4 → data 62,63,0,1 (address wrap); `out_last` on 1.
- base=0, len=64, `out_ready` random 50% → all 0..63 in order, no loss or duplication; `rom_en` never issues with occupancy+in-flight >1; `out_data` stable while stalled.
- len=0 → no `rom_en`, no `out_valid`; `done` one cycle after `start`; `busy` stays 0.
- `start` (base=10, len=8) while busy with (base=0, len=8) → only 0..7 delivered; one `done`.
- `rst` asserted after 3 of 8 words delivered → next cycle all outputs 0 and state IDLE; a following base=20, len=2 command delivers 20,21.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// rom_reader shared types and constants.
// Imported by the reader, its buffer and its bus interface.
package rom_reader_pkg;

  localparam int ROM_DW = 32;
  localparam int ROM_AW = 6;
  localparam int DEPTH  = 2**ROM_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_reader_if.sv
// ROM read port plus valid/ready output stream of rom_reader.
// master = reader side, slave = ROM and stream consumer side.
interface rom_reader_if
  import rom_reader_pkg::*;
#(
  parameter int DW = ROM_DW,
  parameter int AW = ROM_AW
);

  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output rom_en, rom_addr,
    input  rom_dout,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  rom_en, rom_addr,
    output rom_dout,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/rom.sv
// Synchronous single-port ROM, one-cycle read latency.
// Contents are mem[i] = i, produced directly from the address.
module rom
  import rom_reader_pkg::*;
#(
  parameter int DW = ROM_DW,
  parameter int AW = ROM_AW
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout
);

  always_ff @(posedge clk) begin
    if (en) begin
      dout <= DW'(addr);
    end
  end

endmodule

// File: rtl/rom_reader_buf.sv
// Two-entry registered FIFO holding words returned by the ROM.
// Slot 0 is always the head, so rd_data comes straight from a flop.
module rom_reader_buf
  import rom_reader_pkg::*;
#(
  parameter int DW = ROM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last
);

  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          l0_q, l0_d, l1_q, l1_d;
  logic [1:0]    occ_q, occ_d, occ_rem;

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    occ_rem = occ_q - {1'b0, pop};
    if (pop && occ_q == 2'd2) begin
      d0_d = d1_q;
      l0_d = l1_q;
    end
    if (wr_en) begin
      if (occ_rem == 2'd0) begin
        d0_d = wr_data;
        l0_d = wr_last;
      end else begin
        d1_d = wr_data;
        l1_d = wr_last;
      end
    end
    occ_d = occ_rem + {1'b0, wr_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
      occ_q <= occ_d;
    end
  end

  assign occ      = occ_q;
  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = d0_q;
  assign rd_last  = l0_q & rd_valid;

endmodule

// File: rtl/rom_reader.sv
// Read initiator: walks base..base+len-1 through the ROM and streams
// the words out with a last marker, never holding more than two words.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int DW = ROM_DW,
  parameter int AW = ROM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  rom_reader_if.master  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          infl_q, infl_d;
  logic          inlast_q, inlast_d;
  logic          done_q, done_d;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          rem_one;
  logic [2:0]    pending;

  assign pop     = bus.out_valid & bus.out_ready;
  assign rem_one = (rem_q == {{AW{1'b0}}, 1'b1});
  // Words that will still occupy the buffer after this cycle's pop.
  assign pending = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign issue   = (state_q == RUN) && (rem_q != '0)
                && (pending <= 3'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    infl_d   = issue;
    inlast_d = issue & rem_one;
    if (issue) begin
      addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
      rem_d  = rem_q - {{AW{1'b0}}, 1'b1};
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
            addr_d  = base;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && rem_one) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!infl_q && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      infl_q   <= 1'b0;
      inlast_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      infl_q   <= infl_d;
      inlast_q <= inlast_d;
      done_q   <= done_d;
    end
  end

  rom_reader_buf #(.DW(DW)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (infl_q),
    .wr_data  (bus.rom_dout),
    .wr_last  (inlast_q),
    .pop      (pop),
    .occ      (occ),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out_data),
    .rd_last  (bus.out_last)
  );

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign bus.rom_en   = issue;
  assign bus.rom_addr = addr_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a scoreboard of expected words
// and a per-cycle monitor for buffer occupancy and stall stability.
module tb_rom_reader;
  import rom_reader_pkg::*;

  localparam int AW = ROM_AW;
  localparam int DW = ROM_DW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;

  rom_reader_if #(.DW(DW), .AW(AW)) bus ();

  rom_reader #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  rom #(.DW(DW), .AW(AW)) u_rom (
    .clk  (clk),
    .en   (bus.rom_en),
    .addr (bus.rom_addr),
    .dout (bus.rom_dout)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            occ_m = 0;
  int            infl_m = 0;
  bit            stall_p = 1'b0;
  logic [DW-1:0] data_p = '0;
  int            hs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int   pop;
    exp_t e;
    pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
    if (rst) begin
      occ_m   = 0;
      infl_m  = 0;
      stall_p = 1'b0;
      return;
    end
    if (stall_p) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", bus.out_data, data_p);
    end
    chk("valid_vs_occ", 32'(bus.out_valid), 32'(occ_m != 0));
    if (bus.rom_en) begin
      chk("issue_rule", 32'(occ_m + infl_m - pop <= 1), 32'd1);
    end
    if (pop != 0) begin
      hs_cnt++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", bus.out_data, e.data);
        chk("last", 32'(bus.out_last), 32'(e.last));
      end
    end
    occ_m   = occ_m + infl_m - pop;
    infl_m  = bus.rom_en ? 1 : 0;
    stall_p = bus.out_valid && !bus.out_ready;
    data_p  = bus.out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int b, input int n, input bit track);
    exp_t e;
    base  = AW'(b);
    len   = (AW+1)'(n);
    start = 1'b1;
    if (track) begin
      for (int i = 0; i < n; i++) begin
        e.data = DW'((b + i) % DEPTH);
        e.last = (i == n - 1);
        sb.push_back(e);
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int k;
    int n;
    int hs0;
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(bus.rom_en), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // base 2, len 4: exact cycle timing
    cmd(2, 4, 1'b1);
    chk("t1_en", 32'(bus.rom_en), 32'd1);
    chk("t1_addr", 32'(bus.rom_addr), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_v1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_v2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_v3", 32'(bus.out_valid), 32'd1);
    chk("t1_d3", bus.out_data, 32'd2);
    tick();
    tick();
    tick();
    chk("t1_last", 32'(bus.out_last), 32'd1);
    chk("t1_d6", bus.out_data, 32'd5);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy0", 32'(busy), 32'd0);
    tick();
    chk("t1_done0", 32'(done), 32'd0);

    // address wrap
    cmd(62, 4, 1'b1);
    wait_done("t2_done", 20);
    chk("t2_sb", 32'(sb.size()), 32'd0);
    tick();

    // full ROM under random backpressure
    cmd(0, 64, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_sb", 32'(sb.size()), 32'd0);
    bus.out_ready = 1'b1;
    tick();

    // zero-length command
    cmd(5, 0, 1'b1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_en", 32'(bus.rom_en), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t4_done0", 32'(done), 32'd0);
    chk("t4_busy0", 32'(busy), 32'd0);
    chk("t4_valid0", 32'(bus.out_valid), 32'd0);

    // start while busy is ignored
    cmd(0, 8, 1'b1);
    tick();
    tick();
    chk("t5_busy", 32'(busy), 32'd1);
    cmd(10, 8, 1'b0);
    wait_done("t5_done", 30);
    n = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) n++;
    end
    chk("t5_extra_done", 32'(n), 32'd0);
    chk("t5_sb", 32'(sb.size()), 32'd0);

    // reset mid-command
    cmd(0, 8, 1'b1);
    hs0 = hs_cnt;
    k = 0;
    while (hs_cnt - hs0 < 3 && k < 50) begin
      tick();
      k++;
    end
    chk("t6_three", 32'(hs_cnt - hs0), 32'd3);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_en", 32'(bus.rom_en), 32'd0);
    chk("t6_addr", 32'(bus.rom_addr), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_data", bus.out_data, 32'd0);
    chk("t6_last", 32'(bus.out_last), 32'd0);
    tick();
    chk("t6_nodone", 32'(done), 32'd0);
    cmd(20, 2, 1'b1);
    wait_done("t6_done2", 20);
    chk("t6_sb", 32'(sb.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
